// File: rtl/d8_loader_pkg.sv
// rtl/d8_loader_pkg.sv - shared d8 loader definitions: state encodings and parameter defaults.
// Optional checksum stage is controlled by D8_LOADER_CHECKSUM_EN.
package d8_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
`ifdef D8_LOADER_CHECKSUM_EN
    ST_CSUM = 3'd3,
`endif
    ST_FIN  = 3'd4,
    ST_FAIL = 3'd5
  } state_t;

  localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;
  localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd50000;

  // States in which the inter-byte timeout is armed.
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA)
`ifdef D8_LOADER_CHECKSUM_EN
           || (s == ST_CSUM)
`endif
           ;
  endfunction

endpackage

// File: rtl/d8_loader_if.sv
// rtl/d8_loader_if.sv - byte stream input and instruction-memory write port of the d8 loader.
interface d8_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_data
  );
endinterface

// File: rtl/d8_loader_timeout.sv
// rtl/d8_loader_timeout.sv - idle-cycle counter; expired is high once LIMIT idle edges have elapsed.
module d8_loader_timeout #(
  parameter int unsigned LIMIT = 49998
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  assign expired = (count == 16'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/d8_loader.sv
// rtl/d8_loader.sv - framed byte-stream loader for the d8 instruction memory.
// Define D8_LOADER_CHECKSUM_EN to add the trailing checksum byte and its check.
module d8_loader
  import d8_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  d8_loader_if.master bus,
  output logic       core_rst,
  output logic       done,
  output logic       err
);

  // FAIL is entered one edge after expiry and err one edge after that, so the
  // counter limit is trimmed by two to put err exactly TIMEOUT_CYCLES after the last byte.
  localparam int unsigned TO_LIMIT = 32'(TIMEOUT_CYCLES) - 32'd2;

  state_t     state_q, state_d;
  logic [7:0] remain_q;
  logic [7:0] idx_q;
  logic [7:0] sum_q;
  logic       rel_q;
  logic       xfer;
  logic       active;
  logic       expired;
  logic       last_byte;
  logic       is_sync;

  assign bus.rx_ready = (state_q != ST_FIN) && (state_q != ST_FAIL);
  assign xfer         = bus.rx_valid && bus.rx_ready;
  assign active       = in_frame(state_q);
  assign last_byte    = (remain_q == 8'd1);
  assign is_sync      = (bus.rx_data == SYNC_BYTE);

  d8_loader_timeout #(
    .LIMIT (TO_LIMIT)
  ) u_timeout (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .clear   (xfer || !active),
    .enable  (active),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer && is_sync) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (xfer)         state_d = ST_DATA;
        else if (expired) state_d = ST_FAIL;
      end
      ST_DATA: begin
        if (xfer) begin
          if (last_byte) begin
`ifdef D8_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end
        end else if (expired) begin
          state_d = ST_FAIL;
        end
      end
`ifdef D8_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer)         state_d = (bus.rx_data == sum_q) ? ST_FIN : ST_FAIL;
        else if (expired) state_d = ST_FAIL;
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      core_rst      <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
      bus.imem_we   <= 1'b0;
      bus.imem_addr <= 8'h00;
      bus.imem_data <= 8'h00;
      sum_q         <= 8'h00;
      idx_q         <= 8'h00;
      remain_q      <= 8'h00;
      rel_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus.imem_we <= 1'b0;
      rel_q       <= (state_q == ST_FIN);
      if (state_q == ST_FIN)  done <= 1'b1;
      if (state_q == ST_FAIL) err  <= 1'b1;
      // The core leaves reset the cycle after done rises, unless a new frame starts.
      if (rel_q) core_rst <= 1'b0;
      if (xfer) begin
        case (state_q)
          ST_IDLE: begin
            if (is_sync) begin
              core_rst <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
              idx_q    <= 8'h00;
              sum_q    <= 8'h00;
            end
          end
          ST_LEN: remain_q <= bus.rx_data;
          ST_DATA: begin
            bus.imem_we   <= 1'b1;
            bus.imem_addr <= idx_q;
            bus.imem_data <= bus.rx_data;
            idx_q         <= idx_q + 8'd1;
            sum_q         <= sum_q + bus.rx_data;
            remain_q      <= remain_q - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/d8_loader.md
D8_LOADER -- requirements
Module: d8_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd50000, maximum idle cycles between bytes inside a frame.
REQ-003 sys_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 rx_data  input  8  incoming byte from the byte source.
REQ-006 rx_valid  input  1  rx_data is valid this cycle.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both high.
REQ-008 imem_we  output  1  single-cycle instruction-memory write strobe.
REQ-009 imem_addr  output  8  instruction-memory write address.
REQ-010 imem_data  output  8  instruction-memory write data.
REQ-011 core_rst  output  1  reset to the d8 core; high holds the core in reset.
REQ-012 done  output  1  last frame loaded successfully (sticky).
REQ-013 err  output  1  last frame failed (sticky).

Function
REQ-014 Frame format SHALL be: SYNC_BYTE, LEN, LEN data bytes, then CSUM. LEN=0 SHALL mean 256 data bytes.
REQ-015 The FSM SHALL have the states IDLE, LEN, DATA, CSUM, FIN and FAIL.
REQ-016 IDLE: accepted bytes other than SYNC_BYTE SHALL be discarded. An accepted SYNC_BYTE SHALL go to LEN, set core_rst=1, clear done and err, and clear the address and sum.
REQ-017 LEN: the accepted byte SHALL be latched as the remaining count, then go to DATA.
REQ-018 DATA: each accepted byte SHALL produce imem_we=1 exactly one cycle later, with imem_addr = write index and imem_data = byte. The index SHALL then increment, wrapping at 8'hFF. The 8-bit modulo-256 sum SHALL accumulate the byte. After the LEN-th byte, the FSM SHALL go to CSUM.
REQ-019 CSUM: if the accepted byte equals the sum, go to FIN, else go to FAIL.
REQ-020 FIN (1 cycle): done=1, then core_rst=0 from the next cycle; return to IDLE.
REQ-021 FAIL (1 cycle): err=1, core_rst stays 1; return to IDLE.
REQ-022 rx_ready SHALL be 1 in IDLE, LEN, DATA and CSUM, and 0 in FIN and FAIL.
REQ-023 In LEN, DATA and CSUM, a timeout counter SHALL reset on every accepted byte. When it reaches TIMEOUT_CYCLES with no transfer, the FSM SHALL go to FAIL.
REQ-024 A SYNC_BYTE value received in LEN, DATA or CSUM SHALL be treated as ordinary payload, not as a restart.
REQ-025 A transfer offered in the same cycle as a timeout expiry SHALL be accepted, and the timeout SHALL be ignored.
REQ-026 imem_addr and imem_data SHALL hold their last values when imem_we=0.

Reset
REQ-027 On sys_rst=1, the following SHALL be set at the next edge: state=IDLE, core_rst=1, done=0, err=0, imem_we=0, imem_addr=0, imem_data=0, sum=0, timeout counter=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further imem_we pulse, including a pending one.
REQ-029 core_rst SHALL remain 1 after reset until a successful frame completes.

Configuration
REQ-030 With macro D8_LOADER_CHECKSUM_EN defined, the CSUM state and sum check SHALL be present as specified.
REQ-031 Without D8_LOADER_CHECKSUM_EN, the CSUM state SHALL be absent: DATA goes directly to FIN after the LEN-th byte, and FAIL is reachable only by timeout.

Structure
REQ-032 State encodings, the default SYNC_BYTE value and the default TIMEOUT_CYCLES value SHALL live in the shared d8 definitions include.
REQ-033 The timeout counter SHALL be the sub-module d8_loader_timeout, with ports clear, enable and expired.
REQ-034 The loader SHALL be instantiated in d8_top upstream of memi's write port and the regs reset path.

Verification
REQ-035 Sending A5,03,11,22,33,66 SHALL produce writes 0:11, 1:22, 2:33, then done=1 and core_rst falling 2 cycles after the CSUM byte is accepted.
REQ-036 Sending A5,02,10,20,00 (bad sum) SHALL produce 2 writes, then err=1 with core_rst held at 1.
REQ-037 Sending 00,FF before A5,01,AB,AB SHALL discard the leading bytes and then load 0:AB successfully.
REQ-038 Sending A5,00 then 256 bytes 00..FF with the correct CSUM SHALL write all addresses, with the address wrapping to 0, and raise done.
REQ-039 Sending A5,04,01 followed by silence SHALL raise err exactly TIMEOUT_CYCLES cycles after byte 01 is accepted.
REQ-040 Asserting sys_rst after 2 of 4 data bytes SHALL prevent any further imem_we and return all outputs to their reset values.
